conv_encoder_serial: RTL and testbench

Serial convolutional encoder that consumes the one-bit-per-cycle transmit stream from the frame slicer. Each cycle it turns one information bit into one code symbol: 2 bits at rate 1/2, 3 bits at rate 1/3. It frames FRAME_LEN information bits, appends K-1 zero tail bits to terminate the trellis, and hands symbols downstream with a valid strobe and an end-of-frame pulse.

---
 rtl/conv_encoder_serial.sv | 127 ++++++++++++
 tb/tb_conv_encoder_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_serial.sv
// Serial rate-1/2 / rate-1/3 convolutional encoder with per-frame trellis termination.
// Optional: define ENC_TAIL_FLUSH_EN to append K-1 zero tail bits per frame.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module conv_encoder_serial #(
    parameter int unsigned FRAME_LEN = 128,
    parameter int unsigned K         = 3,
    parameter logic [K-1:0] G0       = K'(3'b111),
    parameter logic [K-1:0] G1       = K'(3'b101),
    parameter logic [K-1:0] G2       = K'(3'b111)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_code_rate,
    input  logic       i_valid,
    input  logic       i_tx_data,
    output logic [2:0] o_code,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned MW = K - 1;
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
`ifdef ENC_TAIL_FLUSH_EN
    localparam int unsigned TW = (K > 2) ? $clog2(K - 1) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1
`ifdef ENC_TAIL_FLUSH_EN
        ,
        FLUSH  = 2'd2
`endif
    } state_t;

    state_t         state;
    logic [MW-1:0]  mem;
    logic [CW-1:0]  cnt;
    logic           rate;
`ifdef ENC_TAIL_FLUSH_EN
    logic [TW-1:0]  tail;
`endif

    // Code symbol for input bit b against the current shift memory.
    function automatic logic [2:0] symbol(input logic b, input logic [MW-1:0] m, input logic r);
        logic [K-1:0] v;
        v = {b, m};
        symbol[0] = ^(v & G0);
        symbol[1] = ^(v & G1);
        symbol[2] = (r == `CODE_RATE_3) ? ^(v & G2) : 1'b0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            mem     <= '0;
            cnt     <= '0;
            rate    <= 1'b0;
            o_code  <= 3'b000;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef ENC_TAIL_FLUSH_EN
            tail    <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rate   <= i_code_rate;
                        mem    <= '0;
                        cnt    <= '0;
                        state  <= ENCODE;
                        o_busy <= 1'b1;
                    end
                end
                ENCODE: begin
                    if (i_valid) begin
                        o_code  <= symbol(i_tx_data, mem, rate);
                        o_valid <= 1'b1;
                        mem     <= MW'({i_tx_data, mem} >> 1);
                        cnt     <= cnt + CW'(1);
                        if (cnt == CW'(FRAME_LEN - 1)) begin
`ifdef ENC_TAIL_FLUSH_EN
                            state <= FLUSH;
                            tail  <= '0;
`else
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
`endif
                        end
                    end
                end
`ifdef ENC_TAIL_FLUSH_EN
                // Zero tail bits drive the trellis back to the all-zero state.
                FLUSH: begin
                    o_code  <= symbol(1'b0, mem, rate);
                    o_valid <= 1'b1;
                    mem     <= MW'({1'b0, mem} >> 1);
                    tail    <= tail + TW'(1);
                    if (tail == TW'(K - 2)) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_serial.sv
// Scoreboard bench for conv_encoder_serial (default parameters, K=3, G=111/101/111).
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_conv_encoder_serial;

    localparam int FL = 128;
`ifdef ENC_TAIL_FLUSH_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_code_rate = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_tx_data = 1'b0;
    logic [2:0] o_code;
    logic       o_valid;
    logic       o_busy;
    logic       o_done;

    conv_encoder_serial dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
        .i_valid(i_valid), .i_tx_data(i_tx_data),
        .o_code(o_code), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] code;
        logic       done;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         sym_cnt = 0;
    int         done_cnt = 0;
    logic [1:0] mem_m;     // mem_m[1] is the most recent previous bit
    logic       rate_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder written from the tap equations, not the polynomial masks.
    task automatic push_bit(input logic b, input logic done);
        exp_t e;
        e.code[0] = b ^ mem_m[1] ^ mem_m[0];
        e.code[1] = b ^ mem_m[0];
        e.code[2] = (rate_m == `CODE_RATE_3) ? (b ^ mem_m[1] ^ mem_m[0]) : 1'b0;
        e.done    = done;
        q.push_back(e);
        mem_m = {b, mem_m[1]};
    endtask

    // Output monitor: every o_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && o_valid) begin
            sym_cnt++;
            if (o_done) done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("code", 32'(o_code), 32'(e.code));
                check("done", 32'(o_done), 32'(e.done));
            end
        end else if (rst && o_done) begin
            check("done_without_valid", 32'(o_done), 32'd0);
        end
    end

    task automatic run_frame(input logic rate, input logic [127:0] data,
                             input int stall_at, input int abort_at, input int ctl_at);
        sym_cnt  = 0;
        done_cnt = 0;
        mem_m    = 2'b00;
        rate_m   = rate;
        i_code_rate = rate;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        for (int i = 0; i < FL; i++) begin
            if (i == abort_at) begin
                i_valid = 1'b0;
                rst = 1'b0;
                tick();
                rst = 1'b1;
                @(negedge clk);
                check("abort_outputs", 32'({o_code, o_valid, o_busy, o_done}), 32'd0);
                check("abort_no_done", 32'(done_cnt), 32'd0);
                q.delete();
                tick();
                return;
            end
            if (i == stall_at) begin
                i_valid = 1'b0;
                repeat (5) tick();
            end
            if (i == ctl_at) begin
                i_start = 1'b1;
                i_code_rate = ~rate;
            end else begin
                i_start = 1'b0;
            end
            i_valid   = 1'b1;
            i_tx_data = data[127-i];
            push_bit(i_tx_data, (TAIL == 0) && (i == FL - 1));
            if (i == FL - 1) begin
                for (int t = 0; t < TAIL; t++) push_bit(1'b0, t == TAIL - 1);
            end
            tick();
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) tick();
        check("drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        check("symbol_count", 32'(sym_cnt), 32'(FL + TAIL));
        check("done_count", 32'(done_cnt), 32'd1);
        check("busy_after_frame", 32'(o_busy), 32'd0);
        tick();
    endtask

    initial begin
        logic [127:0] rnd;
        logic [127:0] ones;
        repeat (3) tick();
        check("reset_outputs", 32'({o_code, o_valid, o_busy, o_done}), 32'd0);
        rst = 1'b1;
        tick();

        // Impulse at rate 1/2
        run_frame(`CODE_RATE_2, {1'b1, 127'd0}, -1, -1, -1);
        // 1,0,1,1 then zeros at rate 1/3
        run_frame(`CODE_RATE_3, {4'b1011, 124'd0}, -1, -1, -1);

        // Same random frame with and without a mid-frame stall
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_frame(`CODE_RATE_3, rnd, -1, -1, -1);
        run_frame(`CODE_RATE_3, rnd, 40, -1, -1);

        // i_start and i_code_rate disturbed mid-frame must be ignored
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_frame(`CODE_RATE_2, rnd, -1, -1, 30);
        run_frame(`CODE_RATE_3, rnd, -1, -1, 70);

        // Abort at bit 60, then a fresh frame from zero state
        run_frame(`CODE_RATE_3, {$urandom, $urandom, $urandom, $urandom}, -1, 60, -1);
        run_frame(`CODE_RATE_3, {1'b1, 127'd0}, -1, -1, -1);

        // i_valid in IDLE without i_start produces nothing
        sym_cnt = 0;
        i_valid = 1'b1;
        i_tx_data = 1'b1;
        repeat (6) tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("idle_valid_no_output", 32'(sym_cnt), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        tick();

        // All-ones frame at rate 1/2
        ones = '1;
        run_frame(`CODE_RATE_2, ones, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
